// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the MEM-stage FSM state type.
package cpu_pkg;

  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with a synchronous active-low reset.
// When load_en is high the next instruction's writeback fields are captured.
// When load_en is low a bubble is inserted: regwrite clears, rd and data hold.
import cpu_pkg::*;

module mem_wb_reg #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int RA_W   = cpu_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic              load_en,
  input  logic [DATA_W-1:0] d_writedata,
  input  logic [RA_W-1:0]   d_rd,
  input  logic              d_regwrite,
  output logic [DATA_W-1:0] wb_writedata,
  output logic [RA_W-1:0]   wb_rd,
  output logic              wb_regwrite
);

  // Capture on load, otherwise drop regwrite so a stalled instruction is never written back twice
  always_ff @(posedge clk) begin
    if (!resetl) begin
      wb_writedata <= '0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
    end else if (load_en) begin
      wb_writedata <= d_writedata;
      wb_rd        <= d_rd;
      wb_regwrite  <= d_regwrite;
    end else begin
      wb_regwrite  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs the data-memory req/ack access for the
// instruction held in EX/MEM, stalls the front of the pipe while it is in
// flight, resolves branches, and owns the MEM/WB register.
// Optional build macro MEM_TIMEOUT_EN adds an access timeout with a sticky
// mem_err flag; without it an access waits for ack indefinitely.
import cpu_pkg::*;

module mem_stage_ctrl #(
  parameter int DATA_W         = cpu_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetl,
  input  logic                  mem_zero,
  input  logic [DATA_W-1:0]     mem_aluout,
  input  logic [DATA_W-1:0]     mem_nextseqpc,
  input  logic [DATA_W-1:0]     mem_busB,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_mem2reg,
  input  logic                  mem_regwrite,
  input  logic                  mem_memwrite,
  input  logic                  mem_memread,
  input  logic                  mem_branch,
  input  logic                  mem_uncond_branch,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  stall,
  output logic                  pcsrc,
  output logic [DATA_W-1:0]     branch_target,
  output logic [DATA_W-1:0]     wb_writedata,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_regwrite,
  output logic                  mem_err
);

  mem_state_e        state;
  mem_state_e        state_next;
  logic              memop;
  logic              timeout_hit;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] wb_data_next;

  // A simultaneous read and write is treated as a store through dmem_we
  assign memop = mem_memread | mem_memwrite;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] timeout_cnt;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetl) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and memory-port decode; EX/MEM is frozen during ACCESS so the port is stable until ack
  always_comb begin
    state_next  = state;
    stall       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = '0;
    dmem_wdata  = '0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (memop) begin
          stall      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        stall      = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = mem_memwrite;
        dmem_addr  = mem_aluout;
        dmem_wdata = mem_busB;
        if (dmem_ack) begin
          state_next = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
`endif
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Hold load data from the ack cycle until DONE hands it to MEM/WB
  always_ff @(posedge clk) begin
    if (!resetl) begin
      rdata_q <= '0;
    end else if ((state == ACCESS) && dmem_ack) begin
      rdata_q <= dmem_rdata;
    end else if (timeout_hit) begin
      rdata_q <= '0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Count ack-less ACCESS cycles; held at zero outside ACCESS so each access starts fresh
  always_ff @(posedge clk) begin
    if (!resetl) begin
      timeout_cnt <= '0;
    end else if (state != ACCESS) begin
      timeout_cnt <= '0;
    end else if (!dmem_ack) begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!resetl) begin
      mem_err <= 1'b0;
    end else if (timeout_hit) begin
      mem_err <= 1'b1;
    end
  end
`else
  assign mem_err = 1'b0;
`endif

  // Branch resolution is purely combinational from the EX/MEM bundle
  assign pcsrc         = mem_uncond_branch | (mem_branch & mem_zero);
  assign branch_target = mem_nextseqpc;

  assign wb_data_next = mem_mem2reg ? rdata_q : mem_aluout;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .RA_W   (REG_ADDR_W)
  ) u_mem_wb_reg (
    .clk          (clk),
    .resetl       (resetl),
    .load_en      (~stall),
    .d_writedata  (wb_data_next),
    .d_rd         (mem_rd),
    .d_regwrite   (mem_regwrite),
    .wb_writedata (wb_writedata),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// Covers the MEM_TIMEOUT_EN build when that macro is defined.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        resetl;
  logic        mem_zero;
  logic [63:0] mem_aluout;
  logic [63:0] mem_nextseqpc;
  logic [63:0] mem_busB;
  logic [4:0]  mem_rd;
  logic        mem_mem2reg;
  logic        mem_regwrite;
  logic        mem_memwrite;
  logic        mem_memread;
  logic        mem_branch;
  logic        mem_uncond_branch;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        stall;
  logic        pcsrc;
  logic [63:0] branch_target;
  logic [63:0] wb_writedata;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        mem_err;

  int compared;
  int mismatched;

  mem_stage_ctrl #(
    .DATA_W         (64),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk               (clk),
    .resetl            (resetl),
    .mem_zero          (mem_zero),
    .mem_aluout        (mem_aluout),
    .mem_nextseqpc     (mem_nextseqpc),
    .mem_busB          (mem_busB),
    .mem_rd            (mem_rd),
    .mem_mem2reg       (mem_mem2reg),
    .mem_regwrite      (mem_regwrite),
    .mem_memwrite      (mem_memwrite),
    .mem_memread       (mem_memread),
    .mem_branch        (mem_branch),
    .mem_uncond_branch (mem_uncond_branch),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .stall             (stall),
    .pcsrc             (pcsrc),
    .branch_target     (branch_target),
    .wb_writedata      (wb_writedata),
    .wb_rd             (wb_rd),
    .wb_regwrite       (wb_regwrite),
    .mem_err           (mem_err)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    mem_zero          = 1'b0;
    mem_aluout        = '0;
    mem_nextseqpc     = '0;
    mem_busB          = '0;
    mem_rd            = '0;
    mem_mem2reg       = 1'b0;
    mem_regwrite      = 1'b0;
    mem_memwrite      = 1'b0;
    mem_memread       = 1'b0;
    mem_branch        = 1'b0;
    mem_uncond_branch = 1'b0;
    dmem_ack          = 1'b0;
    dmem_rdata        = '0;
  endtask

  task automatic test_reset;
    resetl = 1'b0;
    clear_inputs();
    tick();
    tick();
    @(negedge clk);
    compared++;
    if (wb_writedata !== 64'h0) begin
      $display("[TB] FAIL reset_wb_writedata: got %h expected %h", wb_writedata, 64'h0);
      mismatched++;
    end
    compared++;
    if (wb_rd !== 5'd0) begin
      $display("[TB] FAIL reset_wb_rd: got %0d expected %0d", wb_rd, 0);
      mismatched++;
    end
    compared++;
    if (wb_regwrite !== 1'b0) begin
      $display("[TB] FAIL reset_wb_regwrite: got %0b expected 0", wb_regwrite);
      mismatched++;
    end
    compared++;
    if (mem_err !== 1'b0) begin
      $display("[TB] FAIL reset_mem_err: got %0b expected 0", mem_err);
      mismatched++;
    end
    compared++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      $display("[TB] FAIL reset_req_stall: got req=%0b stall=%0b expected 0/0", dmem_req, stall);
      mismatched++;
    end
    // Release reset with a stray ack while idle; it must not start anything
    tick();
    resetl   = 1'b1;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    compared++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      $display("[TB] FAIL idle_stray_ack: got req=%0b stall=%0b expected 0/0", dmem_req, stall);
      mismatched++;
    end
  endtask

  task automatic test_alu_op;
    tick();
    clear_inputs();
    mem_regwrite = 1'b1;
    mem_rd       = 5'd5;
    mem_aluout   = 64'h2A;
    @(negedge clk);
    compared++;
    if (stall !== 1'b0) begin
      $display("[TB] FAIL alu_stall: got %0b expected 0", stall);
      mismatched++;
    end
    tick();
    clear_inputs();
    @(negedge clk);
    compared++;
    if (wb_rd !== 5'd5) begin
      $display("[TB] FAIL alu_wb_rd: got %0d expected 5", wb_rd);
      mismatched++;
    end
    compared++;
    if (wb_writedata !== 64'h2A) begin
      $display("[TB] FAIL alu_wb_writedata: got %h expected %h", wb_writedata, 64'h2A);
      mismatched++;
    end
    compared++;
    if (wb_regwrite !== 1'b1) begin
      $display("[TB] FAIL alu_wb_regwrite: got %0b expected 1", wb_regwrite);
      mismatched++;
    end
  endtask

  task automatic test_load;
    int stall_cnt;
    int req_cnt;
    stall_cnt = 0;
    req_cnt   = 0;
    tick();
    clear_inputs();
    mem_memread  = 1'b1;
    mem_mem2reg  = 1'b1;
    mem_regwrite = 1'b1;
    mem_aluout   = 64'h100;
    mem_rd       = 5'd3;
    // Cycle 0 idle-stall, cycles 1..3 access with ack on 3, cycle 4 done
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hDEADBEEF;
      end
      @(negedge clk);
      if (stall === 1'b1) stall_cnt++;
      if (dmem_req === 1'b1) req_cnt++;
      if (c >= 1 && c <= 3) begin
        compared++;
        if (dmem_addr !== 64'h100 || dmem_we !== 1'b0) begin
          $display("[TB] FAIL load_port_c%0d: got addr=%h we=%0b expected addr=%h we=0", c, dmem_addr, dmem_we, 64'h100);
          mismatched++;
        end
        compared++;
        if (wb_regwrite !== 1'b0) begin
          $display("[TB] FAIL load_bubble_c%0d: got wb_regwrite=%0b expected 0", c, wb_regwrite);
          mismatched++;
        end
      end
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = 64'h1111_2222_3333_4444;
    end
    clear_inputs();
    @(negedge clk);
    compared++;
    if (stall_cnt != 4) begin
      $display("[TB] FAIL load_stall_cycles: got %0d expected 4", stall_cnt);
      mismatched++;
    end
    compared++;
    if (req_cnt != 3) begin
      $display("[TB] FAIL load_req_cycles: got %0d expected 3", req_cnt);
      mismatched++;
    end
    compared++;
    if (wb_rd !== 5'd3 || wb_writedata !== 64'hDEADBEEF || wb_regwrite !== 1'b1) begin
      $display("[TB] FAIL load_wb: got rd=%0d data=%h rw=%0b expected rd=3 data=%h rw=1", wb_rd, wb_writedata, wb_regwrite, 64'hDEADBEEF);
      mismatched++;
    end
  endtask

  task automatic test_store;
    tick();
    clear_inputs();
    mem_memwrite = 1'b1;
    mem_aluout   = 64'h40;
    mem_busB     = 64'h55;
    @(negedge clk);
    compared++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      $display("[TB] FAIL store_c0: got stall=%0b req=%0b expected 1/0", stall, dmem_req);
      mismatched++;
    end
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 64'h9999;
    @(negedge clk);
    compared++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 64'h55 || dmem_addr !== 64'h40 || stall !== 1'b1) begin
      $display("[TB] FAIL store_access: got req=%0b we=%0b wdata=%h addr=%h stall=%0b expected 1/1/55/40/1", dmem_req, dmem_we, dmem_wdata, dmem_addr, stall);
      mismatched++;
    end
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    compared++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      $display("[TB] FAIL store_done: got stall=%0b req=%0b expected 0/0", stall, dmem_req);
      mismatched++;
    end
    tick();
    clear_inputs();
    @(negedge clk);
    compared++;
    if (wb_regwrite !== 1'b0) begin
      $display("[TB] FAIL store_wb_regwrite: got %0b expected 0", wb_regwrite);
      mismatched++;
    end
    // Read and write both set behaves as a store
    mem_memread  = 1'b1;
    mem_memwrite = 1'b1;
    mem_aluout   = 64'h48;
    mem_busB     = 64'h66;
    tick();
    dmem_ack = 1'b1;
    @(negedge clk);
    compared++;
    if (dmem_we !== 1'b1 || dmem_wdata !== 64'h66 || dmem_req !== 1'b1) begin
      $display("[TB] FAIL both_bits_store: got we=%0b wdata=%h req=%0b expected 1/66/1", dmem_we, dmem_wdata, dmem_req);
      mismatched++;
    end
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_branch;
    tick();
    clear_inputs();
    mem_branch    = 1'b1;
    mem_zero      = 1'b1;
    mem_nextseqpc = 64'h1234;
    #1;
    compared++;
    if (pcsrc !== 1'b1 || branch_target !== 64'h1234 || stall !== 1'b0) begin
      $display("[TB] FAIL branch_taken: got pcsrc=%0b target=%h stall=%0b expected 1/1234/0", pcsrc, branch_target, stall);
      mismatched++;
    end
    mem_zero = 1'b0;
    #1;
    compared++;
    if (pcsrc !== 1'b0) begin
      $display("[TB] FAIL branch_not_taken: got %0b expected 0", pcsrc);
      mismatched++;
    end
    mem_branch        = 1'b0;
    mem_uncond_branch = 1'b1;
    #1;
    compared++;
    if (pcsrc !== 1'b1) begin
      $display("[TB] FAIL uncond_zero0: got %0b expected 1", pcsrc);
      mismatched++;
    end
    mem_zero = 1'b1;
    #1;
    compared++;
    if (pcsrc !== 1'b1) begin
      $display("[TB] FAIL uncond_zero1: got %0b expected 1", pcsrc);
      mismatched++;
    end
    clear_inputs();
    #1;
    compared++;
    if (pcsrc !== 1'b0) begin
      $display("[TB] FAIL bubble_pcsrc: got %0b expected 0", pcsrc);
      mismatched++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    tick();
    clear_inputs();
    mem_regwrite = 1'b1;
    mem_rd       = 5'd7;
    mem_aluout   = 64'h77;
    tick();
    clear_inputs();
    mem_memread  = 1'b1;
    mem_mem2reg  = 1'b1;
    mem_regwrite = 1'b1;
    mem_rd       = 5'd4;
    mem_aluout   = 64'h300;
    @(negedge clk);
    compared++;
    if (wb_rd !== 5'd7 || wb_writedata !== 64'h77) begin
      $display("[TB] FAIL rma_precondition: got rd=%0d data=%h expected 7/77", wb_rd, wb_writedata);
      mismatched++;
    end
    tick();
    resetl = 1'b0;
    @(negedge clk);
    compared++;
    if (dmem_req !== 1'b1) begin
      $display("[TB] FAIL rma_in_access: got req=%0b expected 1", dmem_req);
      mismatched++;
    end
    tick();
    @(negedge clk);
    compared++;
    if (dmem_req !== 1'b0 || wb_rd !== 5'd0 || wb_writedata !== 64'h0 || wb_regwrite !== 1'b0) begin
      $display("[TB] FAIL rma_after_reset: got req=%0b rd=%0d data=%h rw=%0b expected 0/0/0/0", dmem_req, wb_rd, wb_writedata, wb_regwrite);
      mismatched++;
    end
    tick();
    resetl = 1'b1;
    clear_inputs();
    dmem_ack   = 1'b1;
    dmem_rdata = 64'hBAD;
    @(negedge clk);
    compared++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      $display("[TB] FAIL rma_stray_ack: got req=%0b stall=%0b expected 0/0", dmem_req, stall);
      mismatched++;
    end
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    compared++;
    if (dmem_req !== 1'b0 || wb_regwrite !== 1'b0 || wb_rd !== 5'd0) begin
      $display("[TB] FAIL rma_idle_after: got req=%0b rw=%0b rd=%0d expected 0/0/0", dmem_req, wb_regwrite, wb_rd);
      mismatched++;
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    // Prime the load-data holding register with a nonzero value
    tick();
    clear_inputs();
    mem_memread = 1'b1;
    mem_mem2reg = 1'b1;
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 64'hABCD;
    tick();
    clear_inputs();
    tick();
    // Load that never sees ack
    mem_memread  = 1'b1;
    mem_mem2reg  = 1'b1;
    mem_regwrite = 1'b1;
    mem_rd       = 5'd9;
    mem_aluout   = 64'h200;
    tick();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      compared++;
      if (dmem_req !== 1'b1 || mem_err !== 1'b0) begin
        $display("[TB] FAIL timeout_access_c%0d: got req=%0b err=%0b expected 1/0", c, dmem_req, mem_err);
        mismatched++;
      end
      tick();
    end
    @(negedge clk);
    compared++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b1) begin
      $display("[TB] FAIL timeout_done: got req=%0b stall=%0b err=%0b expected 0/0/1", dmem_req, stall, mem_err);
      mismatched++;
    end
    tick();
    clear_inputs();
    @(negedge clk);
    compared++;
    if (wb_writedata !== 64'h0 || wb_rd !== 5'd9 || wb_regwrite !== 1'b1) begin
      $display("[TB] FAIL timeout_wb: got data=%h rd=%0d rw=%0b expected 0/9/1", wb_writedata, wb_rd, wb_regwrite);
      mismatched++;
    end
    tick();
    tick();
    @(negedge clk);
    compared++;
    if (mem_err !== 1'b1) begin
      $display("[TB] FAIL timeout_sticky: got %0b expected 1", mem_err);
      mismatched++;
    end
    // Reset, then ack exactly on the limit cycle wins
    resetl = 1'b0;
    tick();
    resetl       = 1'b1;
    mem_memread  = 1'b1;
    mem_mem2reg  = 1'b1;
    mem_regwrite = 1'b1;
    mem_rd       = 5'd10;
    mem_aluout   = 64'h208;
    @(negedge clk);
    compared++;
    if (mem_err !== 1'b0) begin
      $display("[TB] FAIL timeout_reset_clears: got %0b expected 0", mem_err);
      mismatched++;
    end
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hCAFE;
      end
      tick();
      dmem_ack = 1'b0;
    end
    @(negedge clk);
    compared++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b0) begin
      $display("[TB] FAIL limit_ack_done: got req=%0b stall=%0b err=%0b expected 0/0/0", dmem_req, stall, mem_err);
      mismatched++;
    end
    tick();
    clear_inputs();
    @(negedge clk);
    compared++;
    if (wb_writedata !== 64'hCAFE || wb_rd !== 5'd10 || mem_err !== 1'b0) begin
      $display("[TB] FAIL limit_ack_wb: got data=%h rd=%0d err=%0b expected cafe/10/0", wb_writedata, wb_rd, mem_err);
      mismatched++;
    end
  endtask
`else
  task automatic test_no_timeout;
    int req_cnt;
    req_cnt = 0;
    tick();
    clear_inputs();
    mem_memread  = 1'b1;
    mem_mem2reg  = 1'b1;
    mem_regwrite = 1'b1;
    mem_rd       = 5'd12;
    mem_aluout   = 64'h500;
    tick();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dmem_req === 1'b1 && stall === 1'b1) req_cnt++;
      tick();
    end
    compared++;
    if (req_cnt != 20 || mem_err !== 1'b0) begin
      $display("[TB] FAIL no_timeout_wait: got req_cycles=%0d err=%0b expected 20/0", req_cnt, mem_err);
      mismatched++;
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 64'h5A5A;
    tick();
    dmem_ack = 1'b0;
    tick();
    clear_inputs();
    @(negedge clk);
    compared++;
    if (wb_writedata !== 64'h5A5A || wb_rd !== 5'd12 || wb_regwrite !== 1'b1) begin
      $display("[TB] FAIL no_timeout_wb: got data=%h rd=%0d rw=%0b expected 5a5a/12/1", wb_writedata, wb_rd, wb_regwrite);
      mismatched++;
    end
  endtask
`endif

  // Run each scenario in order and report
  initial begin
    compared   = 0;
    mismatched = 0;
    resetl     = 1'b0;
    clear_inputs();
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_branch();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
